// File: rtl/instruction_fetch.sv
// IF-stage fetch initiator: owns the PC, drives the synchronous instruction memory,
// and pairs each returned word with its PC for decode under a valid/stall handshake.
module instruction_fetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    output logic [31:0]           fetch_count
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight_valid;
    logic                  hold;
    logic                  accept;

    // A stall only freezes fetch when there is a word to hold; an empty pipe keeps fetching.
    assign hold        = stall && inflight_valid;
    assign instr_valid = inflight_valid && !redirect_valid;
    assign accept      = instr_valid && !stall;
    assign instr_out   = mem_data;
    assign instr_pc    = inflight_pc;

    always_comb begin
        mem_address = pc;
        if (redirect_valid) begin
            mem_address = redirect_target;
        end else if (hold) begin
            mem_address = inflight_pc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc             <= RESET_PC;
            inflight_pc    <= RESET_PC;
            inflight_valid <= 1'b0;
            fetch_count    <= '0;
        end else begin
            if (accept) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect_valid) begin
                inflight_pc    <= redirect_target;
                inflight_valid <= 1'b1;
                pc             <= redirect_target + PC_STEP;
            end else if (!hold) begin
                inflight_pc    <= pc;
                inflight_valid <= 1'b1;
                pc             <= pc + PC_STEP;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: synchronous memory model plus a queue of
// expected per-cycle outputs consumed as the DUT presents them.
module tb_instruction_fetch;

    logic        clock;
    logic        reset_n;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] fetch_count;

    int compared;
    int mismatched;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [256];

    instruction_fetch #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC(32'h0)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .mem_address(mem_address),
        .mem_data(mem_data),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .instr_out(instr_out),
        .instr_pc(instr_pc),
        .instr_valid(instr_valid),
        .fetch_count(fetch_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h100 + 32'(i);
    end

    // Word-indexed synchronous memory; the index is masked to the model depth.
    always @(posedge clock) mem_data <= mem[mem_address[7:0]];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic v, input logic [31:0] pc);
        exp_t e;
        e.v  = v;
        e.pc = pc;
        e.d  = 32'h100 + {24'h0, pc[7:0]};
        exp_q.push_back(e);
    endtask

    // Drive one cycle's inputs, check the outputs of that cycle, then advance past the edge.
    task automatic cyc(input logic st, input logic rv, input logic [31:0] tgt,
                       input bit do_ma, input logic [31:0] ma);
        exp_t e;
        stall           = st;
        redirect_valid  = rv;
        redirect_target = tgt;
        #2;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL scoreboard: observed=empty expected=entry");
        end else begin
            e = exp_q.pop_front();
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, e.v});
            if (e.v) begin
                chk("instr_pc", instr_pc, e.pc);
                chk("instr_out", instr_out, e.d);
            end
        end
        if (do_ma) chk("mem_address", mem_address, ma);
        @(posedge clock);
        #1;
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        reset_n         = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_valid", {31'b0, instr_valid}, 32'h0);
        chk("reset_mem_address", mem_address, 32'h0);
        chk("reset_fetch_count", fetch_count, 32'h0);
        reset_n = 1'b1;

        // Sequential fetch from reset
        push(1'b0, 32'h0); cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        push(1'b1, 32'h0); cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        push(1'b1, 32'h1); cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Three stalled cycles holding pc 2, then release
        for (int k = 0; k < 3; k++) begin
            push(1'b1, 32'h2); cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h2);
        end
        push(1'b1, 32'h2); cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        push(1'b1, 32'h3); cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("count_after_stall", fetch_count, 32'd4);
        push(1'b1, 32'h4); cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Redirect while pc 5 is on the output
        push(1'b0, 32'h5);  cyc(1'b0, 1'b1, 32'h10, 1'b1, 32'h10);
        push(1'b1, 32'h10); cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        push(1'b1, 32'h11); cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("count_after_redirect", fetch_count, 32'd7);

        // Redirect and stall together: redirect wins
        push(1'b0, 32'h12); cyc(1'b1, 1'b1, 32'h08, 1'b1, 32'h08);
        push(1'b1, 32'h08); cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        push(1'b1, 32'h09); cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("count_after_redir_stall", fetch_count, 32'd9);

        // Asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, instr_valid}, 32'h0);
        chk("async_mem_address", mem_address, 32'h0);
        chk("async_fetch_count", fetch_count, 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        exp_q.delete();

        // Stall with nothing in flight is ignored
        push(1'b0, 32'h0); cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
        push(1'b1, 32'h0); cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        push(1'b1, 32'h1); cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Redirect to the top of the address space and wrap
        push(1'b0, 32'h2);        cyc(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
        push(1'b1, 32'hFFFF_FFFF); cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        push(1'b1, 32'h0);        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h1);
        push(1'b1, 32'h1);        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("count_after_wrap", fetch_count, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch-side initiator for the synchronous, word-indexed instruction memory of the IF stage. Owns the program counter and presents one word address per cycle. Pairs each returned word with the PC that requested it and hands the pair to decode with a valid/stall handshake. Accepts branch/jump redirects from later stages.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address (word index)
DATA_WIDTH, 32, instruction width
RESET_PC, 0, first word address fetched after reset

Ports:
clock  in  1  single clock; all state updates on posedge
reset_n  in  1  asynchronous, active-low reset
mem_address  out  ADDR_WIDTH  word address to instruction memory; memory samples it at posedge and returns the word next cycle
mem_data  in  DATA_WIDTH  instruction word from memory, valid one cycle after address sampled
stall  in  1  decode cannot accept the current output
redirect_valid  in  1  control-flow redirect request
redirect_target  in  ADDR_WIDTH  new word address
instr_out  out  DATA_WIDTH  instruction to decode
instr_pc  out  ADDR_WIDTH  word address of instr_out
instr_valid  out  1  instr_out/instr_pc meaningful
fetch_count  out  32  number of instructions accepted by decode

Behaviour:
- State: pc, inflight_pc, inflight_valid, fetch_count.
- Reset (async, reset_n=0, no clock needed): pc=RESET_PC, inflight_pc=RESET_PC, inflight_valid=0, fetch_count=0. Hence instr_valid=0 and mem_address=RESET_PC.
- mem_address is combinational, evaluated in priority order:
  - redirect_valid: redirect_target.
  - stall and inflight_valid: inflight_pc (re-read the held word).
  - otherwise: pc.
- instr_out = mem_data (pass-through; don't-care when instr_valid=0).
- instr_pc = inflight_pc.
- instr_valid = inflight_valid and not redirect_valid (the wrong-path word is squashed combinationally in a redirect cycle).
- Accept: a posedge where instr_valid=1 and stall=0.
- Per posedge, in priority order:
  - redirect_valid=1 (wins over stall): inflight_pc<=redirect_target, inflight_valid<=1, pc<=redirect_target+1.
  - stall=1 and inflight_valid=1: pc, inflight_pc and inflight_valid hold. Memory re-reads inflight_pc, so mem_data stays stable.
  - otherwise (stall=0, or nothing in flight): inflight_pc<=pc, inflight_valid<=1, pc<=pc+1.
- Stall with inflight_valid=0 is ignored; there is nothing to hold.
- fetch_count increments by 1 on each accept and wraps at 2^32.
- Latency: the first valid instruction appears the cycle after the first posedge following reset release. Throughput is 1 instruction/cycle with no stalls. A redirect costs exactly one squashed slot; the target is on the output the cycle after the redirect.
- PC arithmetic is modulo 2^ADDR_WIDTH, so 2^ADDR_WIDTH-1 wraps to 0.
- Reset asserted mid-operation discards the in-flight word immediately. No memory request is outstanding after release.
- No instruction is skipped or duplicated across any stall/redirect sequence.

Test Plan:
1. Memory model mem[i]=0x100+i; release reset. Cycle after first edge: instr_valid=1, instr_pc=0, instr_out=0x100. Following cycles show pc 1, 2, 3 with 0x101, 0x102, 0x103.
2. Assert stall for 3 cycles while instr_pc=2. Output holds pc=2/0x102 and mem_address=2 during the stall. After release, pc 3 follows; fetch_count counts pc 2 exactly once.
3. Redirect to 0x10 while instr_pc=5. instr_valid=0 that cycle. Next cycles show instr_pc=0x10/0x110, then 0x11/0x111. fetch_count does not count pc 5.
4. redirect_valid=1 and stall=1 in the same cycle, target 0x08. mem_address=0x08 that cycle. Next cycle instr_pc=0x08, instr_valid=1.
5. Drop reset_n between clock edges mid-run. Immediately instr_valid=0, mem_address=RESET_PC, fetch_count=0. After release, fetch restarts at RESET_PC.
6. Redirect to 0xFFFFFFFF with mem model masking the index. Outputs instr_pc=0xFFFFFFFF then 0x00000000, both valid.
